sr_dmem_port: RTL and testbench
===============================

Name: sr_dmem_port

Overview:
- Data-memory responder for the sub-word access controls issued by the CPU decoder: dm_we, dm_sign, and the one-hot dm_op_byte / dm_op_half / dm_op_word.
- Converts each byte/half/word load or store into a word-wide handshaked memory-bus transaction: lane steering, byte enables, load extraction and sign/zero extension.
- Raises stall while a bus transaction is outstanding so the single-cycle core freezes its PC.
- Sits between the core datapath (ALU result as address, rd2 as store data) and the data RAM.

Parameters:
- ADDR_WIDTH, 32, byte-address width from the CPU; mem_addr is ADDR_WIDTH-2 bits (word address).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  load/store present this cycle (memToReg | dmWe)
- dm_we  in  1  1 = store, 0 = load
- dm_sign  in  1  signed load extension
- dm_op_byte  in  1  byte access
- dm_op_half  in  1  halfword access
- dm_op_word  in  1  word access
- cpu_addr  in  ADDR_WIDTH  byte address
- cpu_wdata  in  32  store data, right-aligned
- cpu_rdata  out  32  extended load result, valid while cpu_done=1
- cpu_done  out  1  one-cycle pulse: access complete
- stall  out  1  hold the CPU (combinational)
- misaligned  out  1  access rejected (combinational)
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  bus write
- mem_be  out  4  byte enables
- mem_addr  out  ADDR_WIDTH-2  word address
- mem_wdata  out  32  lane-steered write data
- mem_rdata  in  32  read word, valid with mem_ack
- mem_ack  in  1  responder completion, any latency >= 0 cycles after mem_req rises

Behaviour:
- Reset (async, immediate): state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, cpu_rdata and cpu_done all 0. Reset mid-transaction drops mem_req at once; the access is abandoned.
- Op decode priority: word > half > byte. No op bit set is treated as word.
- misaligned = cpu_req & state==IDLE & ((half & addr[0]) | (word & addr[1:0]!=0)).
  - No bus activity, stall=0, cpu_done=0, stores dropped.
- States: IDLE, BUS, DONE (plus RD and WR when RMW is enabled, see Optional Feature).
- IDLE with cpu_req & ~misaligned:
  - stall=1.
  - Latch address, op, sign and lane-steered data; register mem_req=1 and go to BUS.
- Store steering (applies to mem_be and mem_wdata):
  - byte: wdata[7:0] replicated to all 4 lanes, be = 1 << addr[1:0].
  - half: wdata[15:0] replicated, be = 4'b0011 << (2*addr[1]).
  - word: be = 4'b1111.
- Loads: mem_we=0, mem_be=4'b1111.
- BUS: stall=1. Outputs held stable until mem_ack.
  - On mem_ack: mem_req=0; go to DONE.
  - Loads also register cpu_rdata:
    - byte: lane addr[1:0].
    - half: lane addr[1].
    - Sign-extend if dm_sign, else zero-extend.
- DONE: stall=0, cpu_done=1 for exactly one cycle, then IDLE. A new request cannot be accepted in DONE; cpu_req seen in DONE is ignored.
- Stores leave cpu_rdata at 0.
- Total latency with zero-wait ack: 2 stall cycles, then done.
- cpu_req deasserting during BUS does not abort the transaction.

Optional Feature:
- Macro: SR_DMEM_RMW_EN.
- Defined (RAM without byte enables): every sub-word store runs IDLE -> RD -> WR -> DONE.
  - RD: read with be=1111; on ack, merge new lanes into the read word.
  - WR: write the merged word with be=1111.
  - Word stores and all loads use the single BUS path unchanged.
- Undefined: RD/WR states are absent; sub-word stores use mem_be as above.

Test Plan:
- Reset release, then a word load from addr 0x10 with mem_rdata=0xDEADBEEF and ack the same cycle -> mem_addr=0x4 and be=1111; stall high 2 cycles; cpu_done pulse with cpu_rdata=0xDEADBEEF.
- Signed byte load, addr 0x13, mem_rdata=0x80FF1234 -> cpu_rdata=0xFFFFFF80. Same with dm_sign=0 -> 0x00000080.
- Half store to addr 0x22, wdata=0x0000ABCD, ack delayed 3 cycles -> mem_we=1, be=1100, mem_wdata=0xABCDABCD, outputs stable for 4 cycles, then cpu_done.
- Word load at addr 0x21 -> misaligned=1, stall=0, mem_req never asserted.
- Assert rst while in BUS -> mem_req=0 in the same cycle; state IDLE; the next request proceeds normally.
- With SR_DMEM_RMW_EN: byte store 0x5A to addr 0x01, RAM word 0x11223344 -> one read, then a write of 0x11225A44 with be=1111, then cpu_done.

Source files
------------

// File: rtl/sr_dmem_port.sv
// ============================================================================
// sr_dmem_port : byte/half/word load-store responder driving a word-wide
//                handshaked memory bus. Optional macro: SR_DMEM_RMW_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module sr_dmem_port #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  dm_we,
  input  logic                  dm_sign,
  input  logic                  dm_op_byte,
  input  logic                  dm_op_half,
  input  logic                  dm_op_word,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_done,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

`ifdef SR_DMEM_RMW_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BUS  = 3'd1,
    DONE = 3'd2,
    RD   = 3'd3,
    WR   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BUS  = 3'd1,
    DONE = 3'd2
  } state_t;
`endif

  state_t      state;
  state_t      next_state;

  logic [1:0]  req_sz;
  logic        accept;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  logic [1:0]  lane_q;
  logic [1:0]  sz_q;
  logic        sign_q;
  logic        we_q;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

`ifdef SR_DMEM_RMW_EN
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_mask;
  logic        rmw_path;

  assign merge_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  assign rmw_path   = dm_we & (req_sz != SZ_WORD);
`endif

  // Decode priority word > half > byte; an empty op is a word access.
  always_comb begin
    req_sz = SZ_WORD;
    if (!dm_op_word && dm_op_half) begin
      req_sz = SZ_HALF;
    end else if (!dm_op_word && dm_op_byte) begin
      req_sz = SZ_BYTE;
    end
  end

  assign misaligned = cpu_req && (state == IDLE) &&
                      (((req_sz == SZ_HALF) && cpu_addr[0]) ||
                       ((req_sz == SZ_WORD) && (cpu_addr[1:0] != 2'b00)));
  assign accept     = cpu_req && (state == IDLE) && !misaligned;
  assign cpu_done   = (state == DONE);

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = cpu_wdata;
    case (req_sz)
      SZ_BYTE: begin
        st_be    = 4'b0001 << cpu_addr[1:0];
        st_wdata = {4{cpu_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be    = cpu_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{cpu_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = cpu_wdata;
      end
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (lane_q)
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      2'd3:    byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (sz_q)
      SZ_BYTE: load_val = {{24{sign_q & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_val = {{16{sign_q & half_sel[15]}}, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall      = 1'b1;
`ifdef SR_DMEM_RMW_EN
          next_state = rmw_path ? RD : BUS;
`else
          next_state = BUS;
`endif
        end
      end
      BUS: begin
        stall = 1'b1;
        if (mem_ack) begin
          next_state = DONE;
        end
      end
`ifdef SR_DMEM_RMW_EN
      RD: begin
        stall = 1'b1;
        if (mem_ack) begin
          next_state = WR;
        end
      end
      WR: begin
        stall = 1'b1;
        if (mem_ack) begin
          next_state = DONE;
        end
      end
`endif
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      cpu_rdata <= 32'h0;
      lane_q    <= 2'b00;
      sz_q      <= SZ_WORD;
      sign_q    <= 1'b0;
      we_q      <= 1'b0;
`ifdef SR_DMEM_RMW_EN
      be_q      <= 4'b0000;
      wdata_q   <= 32'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lane_q    <= cpu_addr[1:0];
            sz_q      <= req_sz;
            sign_q    <= dm_sign;
            we_q      <= dm_we;
            mem_req   <= 1'b1;
            mem_addr  <= cpu_addr[ADDR_WIDTH-1:2];
            mem_we    <= dm_we;
            mem_be    <= dm_we ? st_be : 4'b1111;
            mem_wdata <= dm_we ? st_wdata : 32'h0;
`ifdef SR_DMEM_RMW_EN
            be_q      <= st_be;
            wdata_q   <= st_wdata;
            // Sub-word store starts with a full-word read of the target.
            if (rmw_path) begin
              mem_we    <= 1'b0;
              mem_be    <= 4'b1111;
              mem_wdata <= 32'h0;
            end
`endif
          end
        end
        BUS: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            cpu_rdata <= we_q ? 32'h0 : load_val;
          end
        end
`ifdef SR_DMEM_RMW_EN
        RD: begin
          if (mem_ack) begin
            mem_we    <= 1'b1;
            mem_be    <= 4'b1111;
            mem_wdata <= (mem_rdata & ~merge_mask) | (wdata_q & merge_mask);
          end
        end
        WR: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            cpu_rdata <= 32'h0;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sr_dmem_port.sv
// ============================================================================
// tb_sr_dmem_port : randomized self-checking bench against a word-array model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sr_dmem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        dm_we;
  logic        dm_sign;
  logic        dm_op_byte;
  logic        dm_op_half;
  logic        dm_op_word;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        stall;
  logic        misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ram [16];
  logic [31:0] model_ram [16];
  int          lat;
  int          cnt;
  logic        poke_en;
  logic [3:0]  poke_idx;
  logic [31:0] poke_val;

  always #5 clk = ~clk;

  sr_dmem_port #(.ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .dm_we      (dm_we),
    .dm_sign    (dm_sign),
    .dm_op_byte (dm_op_byte),
    .dm_op_half (dm_op_half),
    .dm_op_word (dm_op_word),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_done   (cpu_done),
    .stall      (stall),
    .misaligned (misaligned),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  // Responder: acks after lat wait cycles, honours byte enables on writes.
  assign mem_ack   = mem_req && (cnt >= lat);
  assign mem_rdata = ram[mem_addr[3:0]];

  always @(posedge clk) begin
    if (poke_en) begin
      ram[poke_idx] <= poke_val;
    end else if (mem_req && mem_ack && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) ram[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (rst || !mem_req || mem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    poke_en  = 1'b1;
    poke_idx = idx[3:0];
    poke_val = val;
    model_ram[idx] = val;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // 0 byte, 1 half, 2 word; op is {word, half, byte}
  function automatic int size_of(input logic [2:0] op);
    if (op[2] || op == 3'b000) return 2;
    if (op[1]) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input int sz, input logic sign);
    logic [31:0] w;
    logic [31:0] v;
    w = model_ram[addr[5:2]];
    if (sz == 0) begin
      v = (w >> (8 * addr[1:0])) & 32'hFF;
      if (sign && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (w >> (16 * addr[1])) & 32'hFFFF;
      if (sign && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic access(input logic we, input logic sign, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd, input int latency);
    int          sz;
    int          stalls;
    int          idx;
    bit          mis;
    bit          done;
    bit          seen;
    logic [31:0] exp_rd;
    logic [31:0] exp_be;
    logic [31:0] exp_wd;
    logic [31:0] old_word;
    sz  = size_of(op);
    idx = int'(addr[5:2]);
    mis = (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00);
    exp_rd = we ? 32'h0 : model_load(addr, sz, sign);
    if (sz == 0) begin
      exp_be = 32'd1 << addr[1:0];
      exp_wd = {24'h0, wd[7:0]} * 32'h0101_0101;
    end else if (sz == 1) begin
      exp_be = 32'd3 << (2 * addr[1]);
      exp_wd = {16'h0, wd[15:0]} * 32'h0001_0001;
    end else begin
      exp_be = 32'hF;
      exp_wd = wd;
    end
    if (!we) exp_be = 32'hF;
    old_word = model_ram[idx];
    lat = latency;
    cpu_req    = 1'b1;
    dm_we      = we;
    dm_sign    = sign;
    dm_op_byte = op[0];
    dm_op_half = op[1];
    dm_op_word = op[2];
    cpu_addr   = addr;
    cpu_wdata  = wd;
    @(negedge clk);
    chk("misaligned", {31'h0, misaligned}, {31'h0, mis});
    chk("stall_accept", {31'h0, stall}, {31'h0, !mis});
    chk("req_idle", {31'h0, mem_req}, 32'h0);
    @(posedge clk); #1;
    cpu_req   = 1'b0;
    cpu_addr  = $urandom;
    cpu_wdata = $urandom;
    dm_we     = $urandom_range(0, 1);
    if (mis) begin
      repeat (2) begin
        @(negedge clk);
        chk("mis_no_req", {31'h0, mem_req}, 32'h0);
        chk("mis_no_done", {31'h0, cpu_done}, 32'h0);
      end
      chk("mis_ram", ram[idx], old_word);
      @(posedge clk); #1;
      return;
    end
    stalls = 1;
    done   = 1'b0;
    seen   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (cpu_done) begin
        done = 1'b1;
      end else begin
        if (stall) stalls++;
`ifndef SR_DMEM_RMW_EN
        chk("bus_req", {31'h0, mem_req}, 32'h1);
        chk("bus_addr", {2'b00, mem_addr}, addr >> 2);
        chk("bus_we", {31'h0, mem_we}, {31'h0, we});
        chk("bus_be", {28'h0, mem_be}, exp_be);
        if (we) chk("bus_wdata", mem_wdata, exp_wd);
`endif
        seen = 1'b1;
      end
    end
    if (!done) begin
      chk("done_timeout", 32'h0, 32'h1);
      return;
    end
    chk("bus_seen", {31'h0, seen}, 32'h1);
    chk("stall_at_done", {31'h0, stall}, 32'h0);
    chk("req_at_done", {31'h0, mem_req}, 32'h0);
    chk("rdata", cpu_rdata, exp_rd);
`ifndef SR_DMEM_RMW_EN
    chk("stall_cycles", stalls, latency + 2);
`endif
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (exp_be[b]) model_ram[idx][8*b +: 8] = exp_wd[8*b +: 8];
      end
      chk("ram_word", ram[idx], model_ram[idx]);
    end
    @(negedge clk);
    chk("done_pulse", {31'h0, cpu_done}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; dm_we = 1'b0; dm_sign = 1'b0;
    dm_op_byte = 1'b0; dm_op_half = 1'b0; dm_op_word = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0;
    lat = 0; poke_en = 1'b0; poke_idx = 4'h0; poke_val = 32'h0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    @(negedge clk);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_done", {31'h0, cpu_done}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_addr", {2'b00, mem_addr}, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    poke(4, 32'hDEAD_BEEF);
    access(1'b0, 1'b0, 3'b100, 32'h10, 32'h0, 0);
    poke(4, 32'h80FF_1234);
    access(1'b0, 1'b1, 3'b001, 32'h13, 32'h0, 0);
    access(1'b0, 1'b0, 3'b001, 32'h13, 32'h0, 1);
    poke(8, 32'h0);
    access(1'b1, 1'b0, 3'b010, 32'h22, 32'h0000_ABCD, 3);
    access(1'b0, 1'b0, 3'b100, 32'h21, 32'h0, 0);
    access(1'b1, 1'b0, 3'b010, 32'h23, 32'h1234_5678, 0);
    access(1'b0, 1'b1, 3'b000, 32'h24, 32'h0, 2);
    access(1'b0, 1'b1, 3'b011, 32'h26, 32'h0, 0);

    // Asynchronous reset while a transaction is waiting for its ack.
    lat = 10;
    cpu_req = 1'b1; dm_we = 1'b0; dm_op_word = 1'b1; dm_op_half = 1'b0; dm_op_byte = 1'b0;
    cpu_addr = 32'h14;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst_req", {31'h0, mem_req}, 32'h0);
    chk("midrst_stall", {31'h0, stall}, 32'h0);
    chk("midrst_done", {31'h0, cpu_done}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    access(1'b0, 1'b0, 3'b100, 32'h14, 32'h0, 1);

    for (int i = 0; i < 200; i++) begin
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             {26'h0, 6'($urandom_range(0, 63))}, $urandom, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
